// File: rtl/time_uart_sender_pkg.sv
// Shared constants and state encoding for the time-of-day UART sender.
package time_uart_sender_pkg;

    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
    localparam logic [7:0] ASCII_COLON      = 8'h3A;
    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;

    // Index of the final byte of a message, with and without CR/LF.
    localparam logic [2:0] LAST_IDX_CRLF  = 3'd6;
    localparam logic [2:0] LAST_IDX_PLAIN = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LATCH     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
        return ASCII_DIGIT_BASE + {4'd0, digit};
    endfunction

endpackage

// File: rtl/time_uart_sender_bin_to_bcd2.sv
// Two-digit binary to BCD split; inputs above 59/23 simply yield tens up to 6.
module bin_to_bcd2 (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    // Constant divide/modulo by ten on a 6-bit value reduces to a small table.
    always_comb begin
        tens = 4'(bin / 6'd10);
        ones = 4'(bin % 6'd10);
    end

endmodule

// File: rtl/time_uart_sender.sv
// Streams "HH:MM" (optionally followed by CR LF) into a UART transmitter.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no send in progress; a pending trigger starts one
// ST_LATCH     | time snapshot held, byte index cleared, first byte loaded
// ST_START     | one-cycle start pulse to the transmitter
// ST_WAIT_ACK  | waiting for the transmitter to report busy (txDone=0)
// ST_WAIT_DONE | waiting for the transmitter to finish (txDone=1)
module time_uart_sender
    import time_uart_sender_pkg::*;
#(
    parameter int NrOfDataBits = 8,
    parameter bit AppendCrLf   = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [5:0]              minutes,
    input  logic [5:0]              hours,
    input  logic                    sendRequest,
    input  logic                    autoEnable,
    output logic                    startTransmission,
    output logic [NrOfDataBits-1:0] dataBits,
    input  logic                    txDone,
    output logic                    busy
);

    localparam logic [2:0] LAST_IDX = AppendCrLf ? LAST_IDX_CRLF : LAST_IDX_PLAIN;

    state_t     state_q, state_nxt;
    logic [2:0] idx_q, idx_nxt;
    logic       pending_q, pending_nxt;
    logic       snap_load, data_load;
    logic [5:0] snap_hours, snap_minutes;
    logic [5:0] prev_minutes;
    logic       primed;
    logic       req_d;
    logic       trigger;
    logic [3:0] hours_tens, hours_ones, minutes_tens, minutes_ones;
    logic [7:0] byte_sel;

    // Manual request edge or automatic minute change; the minute compare is
    // held off until the previous-value register has captured a real sample.
    always_comb begin
        trigger = (sendRequest & ~req_d)
                | (autoEnable & primed & (minutes != prev_minutes));
    end

    // Trigger history: request edge detector and previous-minute register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_d        <= 1'b0;
            prev_minutes <= 6'd0;
            primed       <= 1'b0;
        end else begin
            req_d        <= sendRequest;
            prev_minutes <= minutes;
            primed       <= 1'b1;
        end
    end

    bin_to_bcd2 u_hours_bcd (
        .bin  (snap_hours),
        .tens (hours_tens),
        .ones (hours_ones)
    );

    bin_to_bcd2 u_minutes_bcd (
        .bin  (snap_minutes),
        .tens (minutes_tens),
        .ones (minutes_ones)
    );

    // Character for the byte index about to be started.
    always_comb begin
        byte_sel = 8'h00;
        case (idx_nxt)
            3'd0:    byte_sel = digit_to_ascii(hours_tens);
            3'd1:    byte_sel = digit_to_ascii(hours_ones);
            3'd2:    byte_sel = ASCII_COLON;
            3'd3:    byte_sel = digit_to_ascii(minutes_tens);
            3'd4:    byte_sel = digit_to_ascii(minutes_ones);
            3'd5:    byte_sel = ASCII_CR;
            3'd6:    byte_sel = ASCII_LF;
            default: byte_sel = 8'h00;
        endcase
    end

    // Next-state logic. Every trigger funnels through pending, so a trigger
    // in IDLE and one arriving mid-send take the same one-cycle path, and any
    // number of triggers during a send collapse into one follow-up send.
    always_comb begin
        state_nxt   = state_q;
        idx_nxt     = idx_q;
        pending_nxt = pending_q | trigger;
        snap_load   = 1'b0;
        data_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_nxt   = ST_LATCH;
                    pending_nxt = trigger;
                    snap_load   = 1'b1;
                    idx_nxt     = 3'd0;
                end
            end
            ST_LATCH: begin
                state_nxt = ST_START;
                idx_nxt   = 3'd0;
                data_load = 1'b1;
            end
            ST_START: begin
                state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (!txDone) begin
                    state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (txDone) begin
                    if (idx_q == LAST_IDX) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_START;
                        idx_nxt   = idx_q + 3'd1;
                        data_load = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, byte index and pending flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            idx_q     <= idx_nxt;
            pending_q <= pending_nxt;
        end
    end

    // Time snapshot on LATCH entry so the first byte can be registered on
    // LATCH exit; each byte is then held until the next START.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap_hours   <= 6'd0;
            snap_minutes <= 6'd0;
            dataBits     <= '0;
        end else begin
            if (snap_load) begin
                snap_hours   <= hours;
                snap_minutes <= minutes;
            end
            if (data_load) begin
                dataBits <= NrOfDataBits'(byte_sel);
            end
        end
    end

    // Status outputs decode directly from the state so reset clears them at once.
    always_comb begin
        startTransmission = (state_q == ST_START);
        busy              = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_time_uart_sender.sv
// Directed/random bench for time_uart_sender with a simple UART responder.
module tb_time_uart_sender;

    localparam int FRAME = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] minutes, hours;
    logic       sendRequest, autoEnable;
    logic       startTransmission, busy, txDone;
    logic [7:0] dataBits;

    logic       sendRequest2, autoEnable2;
    logic       startTransmission2, busy2, txDone2;
    logic [6:0] dataBits2;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [7:0] cap_q[$];
    logic [7:0] cap2_q[$];
    logic [7:0] exp_q[$];
    int start_cycles  = 0;
    int start_cycles2 = 0;
    int hold_errs     = 0;
    bit abandon       = 1'b0;

    always #10 clock = ~clock;

    time_uart_sender #(.NrOfDataBits(8), .AppendCrLf(1'b1)) dut (
        .clock             (clock),
        .reset             (reset),
        .minutes           (minutes),
        .hours             (hours),
        .sendRequest       (sendRequest),
        .autoEnable        (autoEnable),
        .startTransmission (startTransmission),
        .dataBits          (dataBits),
        .txDone            (txDone),
        .busy              (busy)
    );

    time_uart_sender #(.NrOfDataBits(7), .AppendCrLf(1'b0)) dut2 (
        .clock             (clock),
        .reset             (reset),
        .minutes           (minutes),
        .hours             (hours),
        .sendRequest       (sendRequest2),
        .autoEnable        (autoEnable2),
        .startTransmission (startTransmission2),
        .dataBits          (dataBits2),
        .txDone            (txDone2),
        .busy              (busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference text for one send, built from the time by plain arithmetic.
    task automatic add_frame(input int h, input int m, input bit crlf);
        exp_q.push_back(8'(8'h30 + h / 10));
        exp_q.push_back(8'(8'h30 + h % 10));
        exp_q.push_back(8'h3A);
        exp_q.push_back(8'(8'h30 + m / 10));
        exp_q.push_back(8'(8'h30 + m % 10));
        if (crlf) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        check($sformatf("%s_count", tag), 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_capture();
        cap_q.delete();
        cap2_q.delete();
        exp_q.delete();
        start_cycles  = 0;
        start_cycles2 = 0;
        hold_errs     = 0;
    endtask

    task automatic pulse_request();
        sendRequest = 1'b1;
        cycles(1);
        sendRequest = 1'b0;
    endtask

    // UART responder for dut: busy for FRAME cycles after each start pulse.
    initial begin
        logic [7:0] held;
        txDone = 1'b1;
        forever begin
            @(negedge clock);
            if (startTransmission === 1'b1) begin
                cap_q.push_back(dataBits);
                held   = dataBits;
                txDone = 1'b0;
                repeat (FRAME) @(negedge clock);
                if (!abandon && dataBits !== held) hold_errs++;
                txDone = 1'b1;
            end
        end
    end

    // UART responder for dut2.
    initial begin
        txDone2 = 1'b1;
        forever begin
            @(negedge clock);
            if (startTransmission2 === 1'b1) begin
                cap2_q.push_back({1'b0, dataBits2});
                txDone2 = 1'b0;
                repeat (FRAME) @(negedge clock);
                txDone2 = 1'b1;
            end
        end
    end

    // Start-pulse width monitor: counts every cycle the pulse is high.
    initial begin
        forever begin
            @(negedge clock);
            if (startTransmission === 1'b1)  start_cycles++;
            if (startTransmission2 === 1'b1) start_cycles2++;
        end
    end

    initial begin
        int h, m, lat, seen_activity, waited;
        logic busy_k1, busy_k2;

        reset = 1'b1; minutes = 6'd5; hours = 6'd0;
        sendRequest = 1'b0; autoEnable = 1'b1;
        sendRequest2 = 1'b0; autoEnable2 = 1'b0;
        cycles(3);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_start", {31'd0, startTransmission}, 32'd0);
        check("reset_data", {24'd0, dataBits}, 32'd0);
        reset = 1'b0;
        seen_activity = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (busy !== 1'b0 || startTransmission !== 1'b0) seen_activity++;
        end
        check("post_reset_quiet", 32'(seen_activity), 32'd0);
        autoEnable = 1'b0;
        cycles(2);

        // Directed 09:07 with latency check.
        clear_capture();
        hours = 6'd9; minutes = 6'd7;
        add_frame(9, 7, 1'b1);
        sendRequest = 1'b1;
        lat = -1; busy_k1 = 1'bx; busy_k2 = 1'bx;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (k == 1) begin sendRequest = 1'b0; busy_k1 = busy; end
            if (k == 2) busy_k2 = busy;
            if (startTransmission === 1'b1 && lat < 0) lat = k;
        end
        check("latency_busy_before_latch", {31'd0, busy_k1}, 32'd0);
        check("latency_busy_at_latch", {31'd0, busy_k2}, 32'd1);
        check("latency_start", 32'(lat), 32'd3);
        cycles(400);
        check_bytes("send_0907", cap_q, exp_q);
        check("send_0907_pulses", 32'(start_cycles), 32'd7);
        check("send_0907_hold", 32'(hold_errs), 32'd0);
        check("send_0907_idle", {31'd0, busy}, 32'd0);

        // Random times, including out-of-range values.
        for (int r = 0; r < 3; r++) begin
            clear_capture();
            h = $urandom_range(0, 63); m = $urandom_range(0, 63);
            hours = 6'(h); minutes = 6'(m);
            add_frame(h, m, 1'b1);
            cycles(1);
            pulse_request();
            cycles(400);
            check_bytes($sformatf("rand%0d", r), cap_q, exp_q);
            check($sformatf("rand%0d_pulses", r), 32'(start_cycles), 32'd7);
        end

        // Automatic send on a minute change, and only on a change.
        clear_capture();
        hours = 6'd23; minutes = 6'd58;
        cycles(5);
        autoEnable = 1'b1;
        cycles(5);
        minutes = 6'd59;
        add_frame(23, 59, 1'b1);
        cycles(400);
        check_bytes("auto_2359", cap_q, exp_q);
        cycles(300);
        check("auto_no_repeat", 32'(start_cycles), 32'd7);
        autoEnable = 1'b0;
        cycles(2);

        // Mid-send change plus two requests: snapshot kept, one follow-up.
        clear_capture();
        hours = 6'd12; minutes = 6'd3;
        add_frame(12, 3, 1'b1);
        add_frame(12, 4, 1'b1);
        pulse_request();
        cycles(60);
        minutes = 6'd4;
        pulse_request();
        cycles(2);
        pulse_request();
        cycles(800);
        check_bytes("pending", cap_q, exp_q);
        check("pending_pulses", 32'(start_cycles), 32'd14);
        check("pending_hold", 32'(hold_errs), 32'd0);

        // Short-frame, 7-bit instance with hours=63.
        clear_capture();
        hours = 6'd63; minutes = 6'd0;
        add_frame(63, 0, 1'b0);
        cycles(1);
        sendRequest2 = 1'b1;
        cycles(1);
        sendRequest2 = 1'b0;
        cycles(300);
        check_bytes("short", cap2_q, exp_q);
        check("short_pulses", 32'(start_cycles2), 32'd5);
        check("short_idle", {31'd0, busy2}, 32'd0);
        check("short_other_quiet", 32'(start_cycles), 32'd0);

        // Reset during WAIT_DONE of byte 3, then a clean full send.
        clear_capture();
        h = $urandom_range(0, 23); m = $urandom_range(0, 59);
        hours = 6'(h); minutes = 6'(m);
        pulse_request();
        waited = 0;
        while (cap_q.size() < 4 && waited < 400) begin
            cycles(1);
            waited++;
        end
        check("reset_reach_byte3", 32'(cap_q.size()), 32'd4);
        cycles(5);
        abandon = 1'b1;
        reset = 1'b1;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_start", {31'd0, startTransmission}, 32'd0);
        check("midreset_data", {24'd0, dataBits}, 32'd0);
        cycles(3);
        reset = 1'b0;
        cycles(40);
        abandon = 1'b0;
        clear_capture();
        h = $urandom_range(0, 63); m = $urandom_range(0, 63);
        hours = 6'(h); minutes = 6'(m);
        add_frame(h, m, 1'b1);
        cycles(2);
        pulse_request();
        cycles(400);
        check_bytes("after_reset", cap_q, exp_q);
        check("after_reset_pulses", 32'(start_cycles), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
